// File: rtl/lsu_pkg.sv
// Shared types and lane helpers for the load/store initiator.
// Users of misaligned() decide what to do with it depending on LSU_MISALIGN_SPLIT_EN.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE0 = 3'd1,
    ST_WAIT0  = 3'd2,
    ST_ISSUE1 = 3'd3,
    ST_WAIT1  = 3'd4,
    ST_RESP   = 3'd5
  } state_e;

  // 8-bit enable across two consecutive words; the upper nibble belongs to the second word.
  function automatic logic [7:0] byte_en(input logic [1:0] off, input size_e size);
    logic [7:0] mask;
    case (size)
      SZ_WORD: mask = 8'h0F;
      SZ_HALF: mask = 8'h03;
      SZ_BYTE: mask = 8'h01;
      default: mask = 8'h00;
    endcase
    return mask << off;
  endfunction

  function automatic logic misaligned(input logic [1:0] off, input size_e size);
    logic [7:0] be8;
    be8 = byte_en(off, size);
    return be8[7:4] != 4'b0000;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: positions store data/enables and merges/extends load data.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] wdata_i,
  input  logic [1:0]  off_i,
  input  size_e       size_i,
  input  logic        unsigned_i,
  input  logic [31:0] rd0_i,
  input  logic [31:0] rd1_i,
  output logic [7:0]  be8_o,
  output logic [63:0] wdata64_o,
  output logic [31:0] rdata_o
);

  logic [5:0]  shift;
  logic [31:0] raw;

  assign shift     = {1'b0, off_i, 3'b000};
  assign be8_o     = byte_en(off_i, size_i);
  assign wdata64_o = {32'b0, wdata_i} << shift;
  assign raw       = 32'({rd1_i, rd0_i} >> shift);

  always_comb begin
    rdata_o = raw;
    case (size_i)
      SZ_HALF: rdata_o = unsigned_i ? {16'b0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      SZ_BYTE: rdata_o = unsigned_i ? {24'b0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      default: rdata_o = raw;
    endcase
  end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator: one core request becomes one or two aligned word accesses.
// LSU_MISALIGN_SPLIT_EN: when defined, misaligned accesses are split; otherwise they error.
module lsu_mem_initiator
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_rsp_valid,
  input  logic [31:0]       mem_rdata,
  output logic [2:0]        dbg_state
);

  // Handshakes: req and mem_req transfer on the rising edge where valid && ready are
  // both high; outputs stay stable while valid waits for ready. resp_valid and
  // mem_rsp_valid are single-cycle pulses with no backpressure.

  state_e             state_q, state_d;
  logic               err_q, err_d;
  logic               write_q;
  logic [ADDR_W-3:0]  word_q;
  logic [1:0]         off_q;
  size_e              size_q;
  logic               uns_q;
  logic [31:0]        wdata_q;
  logic [31:0]        rd0_q;
  logic [31:0]        rd1;
  logic               accept;
  logic               bad_req;
  logic [7:0]         be8;
  logic [63:0]        wdata64;
  logic [31:0]        load_data;

  assign accept = req_valid && req_ready;

`ifdef LSU_MISALIGN_SPLIT_EN
  logic [31:0] rd1_q;
  assign bad_req = req_size == 2'b11;
  assign rd1     = rd1_q;
`else
  logic unused_hi;
  assign bad_req   = (req_size == 2'b11) || misaligned(req_addr[1:0], size_e'(req_size));
  assign rd1       = 32'b0;
  assign unused_hi = ^{be8[7:4], wdata64[63:32]};
`endif

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          err_d   = bad_req;
          state_d = bad_req ? ST_RESP : ST_ISSUE0;
        end
      end
      ST_ISSUE0: if (mem_req_ready) state_d = ST_WAIT0;
      ST_WAIT0: begin
        if (mem_rsp_valid) begin
`ifdef LSU_MISALIGN_SPLIT_EN
          state_d = misaligned(off_q, size_q) ? ST_ISSUE1 : ST_RESP;
`else
          state_d = ST_RESP;
`endif
        end
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      ST_ISSUE1: if (mem_req_ready) state_d = ST_WAIT1;
      ST_WAIT1:  if (mem_rsp_valid) state_d = ST_RESP;
`endif
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      err_q   <= 1'b0;
      write_q <= 1'b0;
      word_q  <= '0;
      off_q   <= 2'b00;
      size_q  <= SZ_WORD;
      uns_q   <= 1'b0;
      wdata_q <= 32'b0;
      rd0_q   <= 32'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
      rd1_q   <= 32'b0;
`endif
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (accept) begin
        write_q <= req_write;
        word_q  <= req_addr[ADDR_W-1:2];
        off_q   <= req_addr[1:0];
        size_q  <= size_e'(req_size);
        uns_q   <= req_unsigned;
        wdata_q <= req_wdata;
      end
      if (state_q == ST_WAIT0 && mem_rsp_valid) rd0_q <= mem_rdata;
`ifdef LSU_MISALIGN_SPLIT_EN
      // Cleared per request so aligned loads merge against zero.
      if (accept) rd1_q <= 32'b0;
      else if (state_q == ST_WAIT1 && mem_rsp_valid) rd1_q <= mem_rdata;
`endif
    end
  end

  lsu_align u_align (
    .wdata_i    (wdata_q),
    .off_i      (off_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .rd0_i      (rd0_q),
    .rd1_i      (rd1),
    .be8_o      (be8),
    .wdata64_o  (wdata64),
    .rdata_o    (load_data)
  );

  always_comb begin
    mem_req_valid = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = 32'b0;
    mem_be        = 4'b0;
    if (state_q == ST_ISSUE0) begin
      mem_req_valid = 1'b1;
      mem_we        = write_q;
      mem_addr      = {word_q, 2'b00};
      mem_wdata     = wdata64[31:0];
      mem_be        = be8[3:0];
    end
`ifdef LSU_MISALIGN_SPLIT_EN
    if (state_q == ST_ISSUE1) begin
      mem_req_valid = 1'b1;
      mem_we        = write_q;
      mem_addr      = {word_q + (ADDR_W-2)'(1), 2'b00};
      mem_wdata     = wdata64[63:32];
      mem_be        = be8[7:4];
    end
`endif
  end

  assign req_ready  = state_q == ST_IDLE;
  assign resp_valid = state_q == ST_RESP;
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = (resp_valid && !err_q && !write_q) ? load_data : 32'b0;
  assign dbg_state  = state_q;

endmodule

// File: doc/lsu_mem_initiator.md
# lsu_mem_initiator

Load/store initiator between the single-cycle core's execute stage and a word-organised data memory port. Accepts one load or store per transaction with word/half/byte size and signed/unsigned selection. Converts it to aligned word accesses with byte enables, merges and extends read data, and returns one response. With the split option compiled in, a misaligned access becomes two back-to-back memory transactions.

## Interface
- ADDR_W, 32, byte-address width; data width is fixed at 32.
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  core request present.
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified.
- req_size  in  2  00 word, 01 half, 10 byte, 11 illegal.
- req_unsigned  in  1  0 = sign-extend loads, 1 = zero-extend.
- resp_valid  out  1  one-cycle pulse; no backpressure.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  request was illegal or unsupported; valid with resp_valid.
- mem_req_valid  out  1  memory request.
- mem_req_ready  in  1  memory accepts the request when valid && ready.
- mem_we  out  1  write strobe.
- mem_addr  out  ADDR_W  word-aligned; bits [1:0] are always 0.
- mem_wdata  out  32  lane-positioned write data.
- mem_be  out  4  byte enables; bit i covers byte i.
- mem_rsp_valid  in  1  exactly one per accepted memory request (reads and writes), at the earliest the cycle after acceptance.
- mem_rdata  in  32  read word, valid with mem_rsp_valid.

## Operation
- States: IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP.
- **IDLE**
  - On acceptance, latch the request and compute off = addr[1:0] and n = 4/2/1 bytes.
  - size 11 goes directly to RESP with err=1 and no memory access.
  - Otherwise go to ISSUE0.
- **Lane computation**
  - be8 = ((1<<n)-1) << off (8 bits).
  - wdata64 = {32'b0, wdata} << 8*off.
  - Access 0: address {addr[31:2], 2'b00}, be8[3:0], wdata64[31:0].
  - Access 1: address access-0 address + 4 (modulo 2^ADDR_W wrap), be8[7:4], wdata64[63:32].
- Misaligned means be8[7:4] != 0, i.e. word with off != 0 or half with off == 3.
- ISSUE0 drives access 0 and holds all mem_* outputs stable until mem_req_ready, then goes to WAIT0.
- WAIT0 latches mem_rdata as rd0 on mem_rsp_valid, then goes to ISSUE1 if misaligned, else RESP.
- ISSUE1 and WAIT1 behave the same with access 1; rd1 is latched on response, then go to RESP.
- **Load result**
  - raw = ({rd1, rd0} >> 8*off) truncated to n bytes.
  - The result is then sign- or zero-extended per req_unsigned.
  - For an aligned access, rd1 is treated as 0.
- RESP pulses resp_valid for one cycle, then returns to IDLE.
- mem_rsp_valid outside WAIT0/WAIT1 is ignored.
- mem_req_valid is 0 outside ISSUE0/ISSUE1.

## Timing
- Reset values (asynchronous): state=IDLE, req_ready=1, mem_req_valid=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, resp_valid=0, resp_rdata=0, resp_err=0.
- Reset mid-transaction abandons it silently: no resp_valid, and a late mem_rsp_valid is ignored.
- Latency with a zero-wait memory:
  - Aligned: accept at cycle 0, mem request accepted cycle 1, response cycle 2, resp_valid cycle 3.
  - Split: resp_valid at cycle 5.
  - Illegal: resp_valid at cycle 1.
- Each cycle of mem_req_ready=0 or response delay adds one cycle.
- Only one transaction is outstanding; req_ready is 0 from the cycle after acceptance until IDLE.

## Configuration
- LSU_MISALIGN_SPLIT_EN
  - Defined: misaligned accesses split as above.
  - Undefined: misaligned accesses return resp_err=1, resp_rdata=0, with no memory access; ISSUE1/WAIT1 are not generated.

## Structure
- Package lsu_pkg holds:
  - the size enum (SZ_WORD, SZ_HALF, SZ_BYTE);
  - the state enum;
  - the misalign predicate function;
  - the byte-enable function.
- Sub-module lsu_align is combinational. It performs the write lane shift (wdata64/be8) and the read merge/extend (rd0, rd1, off, size, unsigned → result).

## Test plan
- Store word 0xDEADBEEF at 0x10, then load word at 0x10 → mem_be=1111, mem_addr=0x10, resp_rdata=0xDEADBEEF, resp_valid at cycle 3.
- Store byte 0x80 at 0x13, load signed byte at 0x13 → mem_be=1000, mem_wdata=0x80000000, resp_rdata=0xFFFFFF80; unsigned load → 0x00000080.
- With split enabled, word 0x11223344 at 0x21 → access 0x20 be=1110 wdata=0x22334400, then access 0x24 be=0001 wdata=0x00000011; reload returns 0x11223344.
- Half load at 0xFFFFFFFF with split enabled → second access at 0x00000000; with the macro undefined → resp_err=1 and mem_req_valid never asserts.
- req_size=11 → resp_err=1 at cycle 1. Separately, assert reset while in WAIT0 with mem_rsp_valid pending → no resp_valid, and req_ready=1 after reset.
- Hold mem_req_ready=0 for 3 cycles → mem_addr, mem_be and mem_wdata stay stable, and resp_valid is delayed by 3 cycles.
